// File: rtl/hack_boot_loader_pkg.sv
// hack_boot_loader_pkg: shared word width, ROM depth default and loader state encoding
package hack_boot_loader_pkg;
  localparam int WORD_W = 16;
  localparam int ROM_DEPTH_DEFAULT = 32768;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, DONE, ERROR
  } state_t;
endpackage

// File: rtl/hack_word_assembler.sv
// hack_word_assembler: pairs a latched hi byte with the incoming lo byte into a word
module hack_word_assembler
  import hack_boot_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       hi_en,
  input  logic       lo_en,
  input  logic [7:0] byte_in,
  output word_t      word,
  output logic       valid
);
  logic [7:0] hi_q;
  always_ff @(posedge clock) begin
    if (reset || clear) hi_q <= '0;
    else if (hi_en) hi_q <= byte_in;
  end
  assign word  = {hi_q, byte_in};
  assign valid = lo_en;
endmodule

// File: rtl/hack_boot_loader.sv
// hack_boot_loader: streams a length/words/checksum image into instruction ROM, holding the CPU in reset until verified
module hack_boot_loader
  import hack_boot_loader_pkg::*;
#(
  parameter int ROM_DEPTH = ROM_DEPTH_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output word_t      rom_addr,
  output word_t      rom_data,
  output logic       rom_we,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);
  localparam logic [16:0] DEPTH = 17'(ROM_DEPTH);
  state_t state, next;
  word_t  idx, len, sum, word;
  logic   accept, hi_en, lo_en, word_valid, load_start, last;
  assign byte_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO};
  assign accept     = byte_valid && byte_ready;
  assign hi_en      = accept && state inside {LEN_HI, DATA_HI, SUM_HI};
  assign lo_en      = accept && state inside {LEN_LO, DATA_LO, SUM_LO};
  assign load_start = start && state inside {IDLE, DONE, ERROR};
  assign last       = idx == len - 16'd1;
  assign cpu_reset  = state != DONE;
  assign done       = state == DONE;
  assign error      = state == ERROR;
  hack_word_assembler u_asm (
    .clock  (clock),
    .reset  (reset),
    .clear  (load_start),
    .hi_en  (hi_en),
    .lo_en  (lo_en),
    .byte_in(byte_in),
    .word   (word),
    .valid  (word_valid)
  );
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERROR: next = start ? LEN_HI : state;
      LEN_HI:  next = accept ? LEN_LO : state;
      LEN_LO:  next = !word_valid ? state : ({1'b0, word} > DEPTH) ? ERROR : (word == '0) ? SUM_HI : DATA_HI;
      DATA_HI: next = accept ? DATA_LO : state;
      DATA_LO: next = !word_valid ? state : last ? SUM_HI : DATA_HI;
      SUM_HI:  next = accept ? SUM_LO : state;
      SUM_LO:  next = !word_valid ? state : (word == sum) ? DONE : ERROR;
      default: next = IDLE;
    endcase
  end
  // Word index doubles as the ROM address latched on each data word
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      len      <= '0;
      sum      <= '0;
      rom_we   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      rom_we <= 1'b0;
      if (load_start) begin
        idx <= '0;
        len <= '0;
        sum <= '0;
      end
      if (word_valid && state == LEN_LO) len <= word;
      if (word_valid && state == DATA_LO) begin
        rom_we   <= 1'b1;
        rom_addr <= idx;
        rom_data <= word;
        idx      <= idx + 16'd1;
        sum      <= sum + word;
      end
    end
  end
endmodule

// File: tb/tb_hack_boot_loader.sv
// tb_hack_boot_loader: directed image loads with a scoreboard of expected ROM writes and load outcomes
module tb_hack_boot_loader;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_ready, rom_we, cpu_reset, done, error;
  logic [15:0] rom_addr, rom_data;
  int vectors = 0, miscompares = 0;
  typedef struct {int kind; logic [15:0] addr; logic [15:0] data;} ev_t;
  ev_t q[$];
  logic pd = 1'b0, pe = 1'b0;

  hack_boot_loader dut (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_we(rom_we), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic pop_check(input string name, input int kind, input logic [31:0] act);
    ev_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected event kind %0d value %h, nothing expected", name, kind, act);
    end else begin
      e = q.pop_front();
      check(name, {8'(kind), act}, {8'(e.kind), e.addr, e.data});
    end
  endtask

  // kind 0 = ROM write, 1 = load verified, 2 = load failed
  always @(negedge clock) begin
    if (rom_we) pop_check("rom_write", 0, {rom_addr, rom_data});
    if (done && !pd) begin
      pop_check("done_event", 1, 32'h0);
      check("done_cpu_reset", {39'h0, cpu_reset}, 40'h0);
    end
    if (error && !pe) pop_check("error_event", 2, 32'h0);
    pd = done;
    pe = error;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b1;
    byte_in = b;
    t = 0;
    @(negedge clock);
    while (!byte_ready && t < 20) begin
      t++;
      @(negedge clock);
    end
    if (!byte_ready) check("byte_accept_timeout", 40'h0, 40'h1);
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[], input int gap);
    foreach (b[i]) begin
      send_byte(b[i]);
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_outputs", {3'b0, byte_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error},
          {3'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0});
    sync();
    // good image, with a start pulse mid-load that must be ignored
    push(0, 16'h0000, 16'h0010);
    push(0, 16'h0001, 16'hEC10);
    push(1, 16'h0, 16'h0);
    pulse_start();
    send_bytes('{8'h00, 8'h02, 8'h00, 8'h10}, 0);
    pulse_start();
    send_bytes('{8'hEC, 8'h10, 8'hEC, 8'h20}, 0);
    @(negedge clock);
    check("good_status", {37'h0, cpu_reset, done, error}, {37'h0, 3'b010});
    sync();
    // restart from DONE clears done; bad checksum
    pulse_start();
    @(negedge clock);
    check("restart_status", {36'h0, byte_ready, cpu_reset, done, error}, {36'h0, 4'b1100});
    sync();
    push(0, 16'h0000, 16'h0010);
    push(0, 16'h0001, 16'hEC10);
    push(2, 16'h0, 16'h0);
    send_bytes('{8'h00, 8'h02, 8'h00, 8'h10, 8'hEC, 8'h10, 8'hEC, 8'h21}, 0);
    @(negedge clock);
    check("badsum_status", {37'h0, cpu_reset, done, error}, {37'h0, 3'b101});
    sync();
    // oversize length 0x8001
    push(2, 16'h0, 16'h0);
    pulse_start();
    send_bytes('{8'h80, 8'h01}, 0);
    @(negedge clock);
    check("oversize_status", {37'h0, byte_ready, error, rom_we}, {37'h0, 3'b010});
    sync();
    // empty image with 5-cycle valid gaps
    push(1, 16'h0, 16'h0);
    pulse_start();
    send_bytes('{8'h00, 8'h00, 8'h00, 8'h00}, 5);
    @(negedge clock);
    check("empty_status", {37'h0, cpu_reset, done, error}, {37'h0, 3'b010});
    sync();
    // checksum wraps: FFFF + 0002 + 1234 = 1235
    push(0, 16'h0000, 16'hFFFF);
    push(0, 16'h0001, 16'h0002);
    push(0, 16'h0002, 16'h1234);
    push(1, 16'h0, 16'h0);
    pulse_start();
    send_bytes('{8'h00, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h12, 8'h34, 8'h12, 8'h35}, 0);
    @(negedge clock);
    check("wrap_status", {37'h0, cpu_reset, done, error}, {37'h0, 3'b010});
    sync();
    // length exactly ROM_DEPTH is accepted, then the load is abandoned by reset
    pulse_start();
    send_bytes('{8'h80, 8'h00}, 0);
    @(negedge clock);
    check("maxlen_status", {38'h0, byte_ready, error}, {38'h0, 2'b10});
    sync();
    push(0, 16'h0000, 16'h1234);
    send_bytes('{8'h12, 8'h34, 8'h00}, 0);
    byte_valid = 1'b1;
    byte_in = 8'h55;
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clock);
    check("midload_reset", {3'b0, byte_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error},
          {3'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_no_accept", {38'h0, byte_ready, rom_we}, {38'h0, 2'b00});
    end
    sync();
    byte_valid = 1'b0;
    @(negedge clock);
    check("scoreboard_drained", 40'(q.size()), 40'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
